imem_fetch_responder: RTL and testbench

- Instruction-side responder for the fetch stage. It accepts the fetch address driven by the PC register and returns the 32-bit instruction word to decode.
- It fronts a variable-latency backing instruction memory through a req/ack handshake and keeps a one-entry last-fetch buffer.
- It drives the fetch stall that freezes the PC register while a memory access is outstanding.
- It handles branch-redirect flushes, including a flush that arrives while a memory access is in flight.

---
 rtl/imem_fetch_responder_if.sv | 35 +++
 rtl/imem_fetch_responder.sv | 138 +++++++++++++
 tb/tb_imem_fetch_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : imem_fetch_responder_if
// Brief   : Fetch-side and backing-memory signal bundle for the fetch responder.
// Revision: 1.0
// ============================================================================
interface imem_fetch_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_valid_i;
    logic [ADDR_W-1:0] fetch_addr_i;
    logic              flush_i;
    logic [DATA_W-1:0] instr_o;
    logic              instr_valid_o;
    logic              fetch_stall_o;
    logic              misalign_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    // Responder side
    modport slave (
        input  fetch_valid_i, fetch_addr_i, flush_i, mem_ack_i, mem_rdata_i,
        output instr_o, instr_valid_o, fetch_stall_o, misalign_o, mem_req_o, mem_addr_o
    );

    // Fetch stage and backing memory side
    modport master (
        output fetch_valid_i, fetch_addr_i, flush_i, mem_ack_i, mem_rdata_i,
        input  instr_o, instr_valid_o, fetch_stall_o, misalign_o, mem_req_o, mem_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module  : imem_fetch_responder
// Brief   : Fetch responder with one-entry last-fetch buffer, memory req/ack
//           handshake, PC stall and flush handling of in-flight accesses.
// Revision: 1.0
// ============================================================================
module imem_fetch_responder #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire                           clk,
    input  wire                           rst,
    imem_fetch_responder_if.slave         bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] c_NOP = DATA_W'(NOP_INSTR);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_buf_valid;
    logic [ADDR_W-1:0]   r_buf_tag;
    logic [DATA_W-1:0]   r_buf_data;
    logic [DATA_W-1:0]   r_instr;
    logic                r_instr_valid;
    logic                r_misalign;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;

    logic                w_accept;
    logic                w_misaligned;
    logic                w_hit;
    logic                w_stall;

    assign w_accept     = (r_state == S_IDLE) && bus.fetch_valid_i && !bus.flush_i;
    assign w_misaligned = (bus.fetch_addr_i[1:0] != 2'b00);
    assign w_hit        = r_buf_valid && (r_buf_tag == bus.fetch_addr_i);

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_misaligned && !w_hit) begin
                    w_stall      = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // Stall drops in the ack cycle so the PC advances on the same edge
                w_stall = !bus.mem_ack_i;
                if (bus.mem_ack_i)
                    w_next_state = S_IDLE;
                else if (bus.flush_i)
                    w_next_state = S_DISCARD;
            end
            S_DISCARD: begin
                w_stall = !bus.mem_ack_i;
                if (bus.mem_ack_i)
                    w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid   <= 1'b0;
            r_buf_tag     <= '0;
            r_buf_data    <= '0;
            r_instr       <= c_NOP;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
        end else begin
            // Decode sees each instruction for exactly one cycle, bubbles otherwise
            r_instr       <= c_NOP;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_misaligned) begin
                            r_misalign <= 1'b1;
                        end else if (w_hit) begin
                            r_instr       <= r_buf_data;
                            r_instr_valid <= 1'b1;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= bus.fetch_addr_i;
                        end
                    end
                end
                S_WAIT, S_DISCARD: begin
                    if (bus.mem_ack_i) begin
                        r_buf_valid <= 1'b1;
                        r_buf_tag   <= r_mem_addr;
                        r_buf_data  <= bus.mem_rdata_i;
                        r_mem_req   <= 1'b0;
                        // A flush coinciding with the ack still fills the buffer
                        if (r_state == S_WAIT && !bus.flush_i) begin
                            r_instr       <= bus.mem_rdata_i;
                            r_instr_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_o       = r_instr;
    assign bus.instr_valid_o = r_instr_valid;
    assign bus.fetch_stall_o = w_stall;
    assign bus.misalign_o    = r_misalign;
    assign bus.mem_req_o     = r_mem_req;
    assign bus.mem_addr_o    = r_mem_addr;
endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_fetch_responder
// Brief   : Directed self-checking bench with a transaction-level fetch model.
// Revision: 1.0
// ============================================================================
module tb_imem_fetch_responder;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    imem_fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    imem_fetch_responder #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NOP_INSTR(c_NOP)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: one outstanding access (possibly killed) plus a one-entry buffer
    bit          m_busy, m_killed, m_buf_valid, m_en;
    logic [31:0] m_addr, m_buf_tag, m_buf_data;
    logic [31:0] e_instr;
    bit          e_valid, e_mis, e_req;

    initial m_en = 1'b0;

    function automatic bit model_stall();
        if (m_busy)
            return !bus.mem_ack_i;
        return bus.fetch_valid_i && !bus.flush_i && (bus.fetch_addr_i[1:0] == 2'b00)
               && !(m_buf_valid && m_buf_tag == bus.fetch_addr_i);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_killed = 0; m_buf_valid = 0;
            e_instr = c_NOP; e_valid = 0; e_mis = 0; e_req = 0;
            m_en = 1'b1;
        end else begin
            e_instr = c_NOP; e_valid = 0; e_mis = 0;
            if (m_busy) begin
                if (bus.mem_ack_i) begin
                    m_buf_valid = 1; m_buf_tag = m_addr; m_buf_data = bus.mem_rdata_i;
                    if (!m_killed && !bus.flush_i) begin
                        e_instr = bus.mem_rdata_i; e_valid = 1;
                    end
                    m_busy = 0;
                end else if (bus.flush_i) begin
                    m_killed = 1;
                end
            end else if (bus.fetch_valid_i && !bus.flush_i) begin
                if (bus.fetch_addr_i[1:0] != 2'b00)
                    e_mis = 1;
                else if (m_buf_valid && m_buf_tag == bus.fetch_addr_i) begin
                    e_instr = m_buf_data; e_valid = 1;
                end else begin
                    m_busy = 1; m_killed = 0; m_addr = bus.fetch_addr_i;
                end
            end
            e_req = m_busy;
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            check("instr_o", bus.instr_o, e_instr);
            check("instr_valid_o", 32'(bus.instr_valid_o), 32'(e_valid));
            check("misalign_o", 32'(bus.misalign_o), 32'(e_mis));
            check("mem_req_o", 32'(bus.mem_req_o), 32'(e_req));
            if (e_req)
                check("mem_addr_o", bus.mem_addr_o, m_addr);
            check("fetch_stall_o", 32'(bus.fetch_stall_o), 32'(model_stall()));
            check("valid_and_misalign", 32'(bus.instr_valid_o && bus.misalign_o), 32'd0);
        end
    end

    task automatic drive(input bit v, input logic [31:0] a, input bit fl,
                         input bit ack, input logic [31:0] rd);
        bus.fetch_valid_i = v;
        bus.fetch_addr_i  = a;
        bus.flush_i       = fl;
        bus.mem_ack_i     = ack;
        bus.mem_rdata_i   = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        check("reset instr", bus.instr_o, 32'h0000_0013);
        check("reset valid", 32'(bus.instr_valid_o), 32'd0);
        check("reset req", 32'(bus.mem_req_o), 32'd0);
        check("reset misalign", 32'(bus.misalign_o), 32'd0);

        // Miss on 0x0, ack on the third cycle after accept
        drive(1, 32'h0, 0, 0, 32'h0); #1;
        check("miss0 accept stall", 32'(bus.fetch_stall_o), 32'd1);
        tick();
        check("miss0 req", 32'(bus.mem_req_o), 32'd1);
        check("miss0 wait valid", 32'(bus.instr_valid_o), 32'd0);
        #1 check("miss0 wait1 stall", 32'(bus.fetch_stall_o), 32'd1);
        tick();
        check("miss0 wait2 stall", 32'(bus.fetch_stall_o), 32'd1);
        tick();
        drive(1, 32'h0, 0, 1, 32'h0050_0093); #1;
        check("miss0 ack stall", 32'(bus.fetch_stall_o), 32'd0);
        tick();
        check("miss0 instr", bus.instr_o, 32'h0050_0093);
        check("miss0 valid", 32'(bus.instr_valid_o), 32'd1);

        // Immediate refetch of 0x0 hits
        drive(1, 32'h0, 0, 0, 32'h0); #1;
        check("hit0 stall", 32'(bus.fetch_stall_o), 32'd0);
        tick();
        check("hit0 instr", bus.instr_o, 32'h0050_0093);
        check("hit0 valid", 32'(bus.instr_valid_o), 32'd1);
        check("hit0 req", 32'(bus.mem_req_o), 32'd0);

        // Miss on 0x40, flushed in the 2nd wait cycle, ack two cycles later
        drive(1, 32'h40, 0, 0, 32'h0); tick();
        tick();
        drive(1, 32'h40, 1, 0, 32'h0); tick();
        check("disc req held", 32'(bus.mem_req_o), 32'd1);
        drive(0, 32'h0, 0, 0, 32'h0); tick();
        drive(0, 32'h0, 0, 1, 32'hDEAD_BEEF); #1;
        check("disc ack stall", 32'(bus.fetch_stall_o), 32'd0);
        tick();
        check("disc instr", bus.instr_o, c_NOP);
        check("disc valid", 32'(bus.instr_valid_o), 32'd0);
        check("disc req drop", 32'(bus.mem_req_o), 32'd0);
        drive(1, 32'h40, 0, 0, 32'h0); tick();
        check("hit40 instr", bus.instr_o, 32'hDEAD_BEEF);
        check("hit40 valid", 32'(bus.instr_valid_o), 32'd1);

        // Misaligned fetch
        drive(1, 32'h6, 0, 0, 32'h0); tick();
        check("mis pulse", 32'(bus.misalign_o), 32'd1);
        check("mis instr", bus.instr_o, c_NOP);
        check("mis req", 32'(bus.mem_req_o), 32'd0);
        drive(0, 32'h0, 0, 0, 32'h0); tick();
        check("mis one cycle", 32'(bus.misalign_o), 32'd0);

        // Fetch with flush in IDLE is dropped
        drive(1, 32'h80, 1, 0, 32'h0); tick();
        check("drop req", 32'(bus.mem_req_o), 32'd0);
        check("drop valid", 32'(bus.instr_valid_o), 32'd0);

        // Flush coinciding with ack: buffer filled, nothing to decode
        drive(1, 32'h20, 0, 0, 32'h0); tick();
        drive(1, 32'h20, 1, 1, 32'h1234_5678); tick();
        check("flushack valid", 32'(bus.instr_valid_o), 32'd0);
        drive(1, 32'h20, 0, 0, 32'h0); tick();
        check("flushack hit", bus.instr_o, 32'h1234_5678);

        // Reset during WAIT, stale ack afterwards
        drive(1, 32'h100, 0, 0, 32'h0); tick();
        check("rstw req", 32'(bus.mem_req_o), 32'd1);
        drive(0, 32'h0, 0, 0, 32'h0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstw req drop", 32'(bus.mem_req_o), 32'd0);
        check("rstw instr", bus.instr_o, 32'h0000_0013);
        check("rstw valid", 32'(bus.instr_valid_o), 32'd0);
        check("rstw stall", 32'(bus.fetch_stall_o), 32'd0);
        drive(0, 32'h0, 0, 1, 32'hBAD0_BAD0); tick();
        check("stale valid", 32'(bus.instr_valid_o), 32'd0);
        check("stale req", 32'(bus.mem_req_o), 32'd0);
        drive(1, 32'h0, 0, 0, 32'h0); #1;
        check("post-rst miss stall", 32'(bus.fetch_stall_o), 32'd1);
        tick();
        check("post-rst req", 32'(bus.mem_req_o), 32'd1);
        check("post-rst addr", bus.mem_addr_o, 32'h0);
        drive(1, 32'h0, 0, 1, 32'h0000_0517); tick();
        check("post-rst instr", bus.instr_o, 32'h0000_0517);
        drive(0, 32'h0, 0, 0, 32'h0); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
